// File: rtl/cmos_config_sequencer.sv
// cmos_config_sequencer
//   Command source for the camera I2C write engine. Pulses the sensor reset,
//   waits for the sensor to wake, then walks a {reg, value} table in an
//   external synchronous ROM and hands each pair to the I2C engine over a
//   valid/ready handshake.
//
// Ports
//   clk_i        system clock
//   reset_i      synchronous active-high reset (also resets the I2C engine)
//   start_i      restart pulse, honoured only in DONE or ERROR
//   rom_addr_o   table read address; rom_data_i is valid one cycle later
//   rom_data_i   table entry {reg[15:8], value[7:0]}
//                16'hFFFF = terminator, 16'hFFF0 = delay entry
//   cmd_valid_o  command valid to the I2C engine
//   cmd_ready_i  I2C engine can accept a command
//   cmd_reg_o    register address of the current command
//   cmd_data_o   register value of the current command
//   cmd_done_i   one-cycle pulse: accepted transaction finished
//   cmd_nack_i   qualified by cmd_done_i; 1 = slave NACKed
//   reset_cmos_o active-low sensor reset
//   busy_o       sequence in progress
//   done_o       table completed successfully
//   error_o      sequence aborted on NACK (sticky until start_i)
//
// Build option
//   CMOS_CFG_RETRY_EN  when defined, a NACKed entry is re-issued up to
//                      MAX_RETRIES times before the sequence aborts.
//
// state          | meaning
// ---------------+-----------------------------------------------------
// S_RESET_ASSERT | sensor reset held low for RESET_MS
// S_WAKE         | sensor reset released, waiting WAKE_MS
// S_FETCH        | rom_addr_o presented to the ROM
// S_DECODE       | ROM word sampled and classified
// S_DELAY        | delay entry, idle for DELAY_MS
// S_ISSUE        | cmd_valid_o high until the engine accepts
// S_WAIT_DONE    | waiting for the engine's done pulse
// S_DONE         | table completed
// S_ERROR        | aborted on NACK

module cmos_config_sequencer #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int RESET_MS    = 1,
  parameter int WAKE_MS     = 3,
  parameter int DELAY_MS    = 10,
  parameter int ADDR_W      = 8,
  parameter int MAX_RETRIES = 3
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [15:0]       rom_data_i,
  output logic              cmd_valid_o,
  input  logic              cmd_ready_i,
  output logic [7:0]        cmd_reg_o,
  output logic [7:0]        cmd_data_o,
  input  logic              cmd_done_i,
  input  logic              cmd_nack_i,
  output logic              reset_cmos_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o
);

  localparam int CYC_PER_MS = CLK_FREQ_HZ / 1000;
  localparam int RESET_CYC  = RESET_MS * CYC_PER_MS;
  localparam int WAKE_CYC   = WAKE_MS * CYC_PER_MS;
  localparam int DELAY_CYC  = DELAY_MS * CYC_PER_MS;
  localparam int MAX_RW     = (RESET_CYC > WAKE_CYC) ? RESET_CYC : WAKE_CYC;
  localparam int MAX_CYC    = (MAX_RW > DELAY_CYC) ? MAX_RW : DELAY_CYC;
  localparam int TW         = $clog2(MAX_CYC) + 1;

  // The timer is cleared to zero on entry to every wait state and counts
  // down from there; a wait of N cycles ends when the timer has stepped
  // N-1 times, i.e. when it equals -(N-1). This lets the reset value of
  // zero start the first wait directly, and a zero-length wait still
  // spends exactly one cycle in its state.
  localparam int RESET_STEPS = (RESET_CYC > 1) ? RESET_CYC - 1 : 0;
  localparam int WAKE_STEPS  = (WAKE_CYC > 1) ? WAKE_CYC - 1 : 0;
  localparam int DELAY_STEPS = (DELAY_CYC > 1) ? DELAY_CYC - 1 : 0;
  localparam logic [TW-1:0] RESET_TC = TW'(0) - TW'(RESET_STEPS);
  localparam logic [TW-1:0] WAKE_TC  = TW'(0) - TW'(WAKE_STEPS);
  localparam logic [TW-1:0] DELAY_TC = TW'(0) - TW'(DELAY_STEPS);
  localparam logic [TW-1:0] T_ONE    = TW'(1);

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
  localparam logic [15:0] ENTRY_END   = 16'hFFFF;
  localparam logic [15:0] ENTRY_DELAY = 16'hFFF0;

  typedef enum logic [3:0] {
    S_RESET_ASSERT,
    S_WAKE,
    S_FETCH,
    S_DECODE,
    S_DELAY,
    S_ISSUE,
    S_WAIT_DONE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] index;
  logic [TW-1:0]     timer;

`ifdef CMOS_CFG_RETRY_EN
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRIES);
  logic [RW-1:0] retry_cnt;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state        <= S_RESET_ASSERT;
      reset_cmos_o <= 1'b0;
      cmd_valid_o  <= 1'b0;
      rom_addr_o   <= '0;
      cmd_reg_o    <= '0;
      cmd_data_o   <= '0;
      busy_o       <= 1'b1;
      done_o       <= 1'b0;
      error_o      <= 1'b0;
      index        <= '0;
      timer        <= '0;
`ifdef CMOS_CFG_RETRY_EN
      retry_cnt    <= '0;
`endif
    end else begin
      case (state)
        S_RESET_ASSERT: begin
          if (timer == RESET_TC) begin
            reset_cmos_o <= 1'b1;
            timer        <= '0;
            state        <= S_WAKE;
          end else begin
            timer <= timer - T_ONE;
          end
        end

        S_WAKE: begin
          if (timer == WAKE_TC) begin
            // Address goes out on entry to FETCH so the ROM word is
            // available during DECODE.
            rom_addr_o <= index;
            state      <= S_FETCH;
          end else begin
            timer <= timer - T_ONE;
          end
        end

        S_FETCH: state <= S_DECODE;

        S_DECODE: begin
          if (rom_data_i == ENTRY_END) begin
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= S_DONE;
          end else if (rom_data_i == ENTRY_DELAY) begin
            timer <= '0;
            state <= S_DELAY;
          end else begin
            cmd_reg_o   <= rom_data_i[15:8];
            cmd_data_o  <= rom_data_i[7:0];
            cmd_valid_o <= 1'b1;
            state       <= S_ISSUE;
          end
        end

        S_DELAY: begin
          if (timer == DELAY_TC) begin
            if (index == LAST_IDX) begin
              done_o <= 1'b1;
              busy_o <= 1'b0;
              state  <= S_DONE;
            end else begin
              index      <= index + IDX_ONE;
              rom_addr_o <= index + IDX_ONE;
              state      <= S_FETCH;
            end
          end else begin
            timer <= timer - T_ONE;
          end
        end

        S_ISSUE: begin
          if (cmd_ready_i) begin
            cmd_valid_o <= 1'b0;
            state       <= S_WAIT_DONE;
          end
        end

        S_WAIT_DONE: begin
          if (cmd_done_i) begin
            if (cmd_nack_i) begin
`ifdef CMOS_CFG_RETRY_EN
              if (retry_cnt < RETRY_LIM) begin
                retry_cnt   <= retry_cnt + RW'(1);
                cmd_valid_o <= 1'b1;
                state       <= S_ISSUE;
              end else begin
                error_o <= 1'b1;
                busy_o  <= 1'b0;
                done_o  <= 1'b0;
                state   <= S_ERROR;
              end
`else
              error_o <= 1'b1;
              busy_o  <= 1'b0;
              done_o  <= 1'b0;
              state   <= S_ERROR;
`endif
            end else begin
`ifdef CMOS_CFG_RETRY_EN
              retry_cnt <= '0;
`endif
              if (index == LAST_IDX) begin
                done_o <= 1'b1;
                busy_o <= 1'b0;
                state  <= S_DONE;
              end else begin
                index      <= index + IDX_ONE;
                rom_addr_o <= index + IDX_ONE;
                state      <= S_FETCH;
              end
            end
          end
        end

        S_DONE, S_ERROR: begin
          if (start_i) begin
            done_o       <= 1'b0;
            error_o      <= 1'b0;
            busy_o       <= 1'b1;
            index        <= '0;
            rom_addr_o   <= '0;
            timer        <= '0;
            reset_cmos_o <= 1'b0;
            state        <= S_RESET_ASSERT;
`ifdef CMOS_CFG_RETRY_EN
            retry_cnt    <= '0;
`endif
          end
        end

        default: state <= S_RESET_ASSERT;
      endcase
    end
  end

endmodule

// File: tb/tb_cmos_config_sequencer.sv
// Self-checking bench for cmos_config_sequencer. A small I2C engine model
// accepts commands, answers with done 4 cycles after each accept and NACKs
// a chosen range of transfers; a registered ROM model holds the table.
module tb_cmos_config_sequencer;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          start_i;
  logic [AW-1:0] rom_addr_o;
  logic [15:0]   rom_data_i;
  logic          cmd_valid_o;
  logic          cmd_ready_i;
  logic [7:0]    cmd_reg_o;
  logic [7:0]    cmd_data_o;
  logic          cmd_done_i;
  logic          cmd_nack_i;
  logic          reset_cmos_o;
  logic          busy_o;
  logic          done_o;
  logic          error_o;

  logic          ready_en;

  always #5 clk = ~clk;

  assign cmd_ready_i = ready_en;

  cmos_config_sequencer #(
    .CLK_FREQ_HZ(1000),
    .RESET_MS   (2),
    .WAKE_MS    (3),
    .DELAY_MS   (4),
    .ADDR_W     (AW),
    .MAX_RETRIES(3)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .start_i     (start_i),
    .rom_addr_o  (rom_addr_o),
    .rom_data_i  (rom_data_i),
    .cmd_valid_o (cmd_valid_o),
    .cmd_ready_i (cmd_ready_i),
    .cmd_reg_o   (cmd_reg_o),
    .cmd_data_o  (cmd_data_o),
    .cmd_done_i  (cmd_done_i),
    .cmd_nack_i  (cmd_nack_i),
    .reset_cmos_o(reset_cmos_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .error_o     (error_o)
  );

  logic [15:0] rom [DEPTH];
  always @(posedge clk) rom_data_i <= rom[rom_addr_o];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Engine model and handshake monitor, evaluated just after each falling
  // edge so everything it reads is stable until the next rising edge.
  int         xfer_n = 0;
  logic [7:0] xreg [64];
  logic [7:0] xdat [64];
  int         gap  [64];
  int         run = 0;
  int         cnt = 0;
  logic       pend_nack = 1'b0;
  int         nack_at = -1;
  int         nack_cnt = 0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_reg, prev_dat;

  always @(negedge clk) begin
    #1;
    cmd_done_i = 1'b0;
    cmd_nack_i = 1'b0;
    if (reset_i) begin
      cnt       = 0;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold)
        check("hold_stable", {15'd0, cmd_valid_o, cmd_reg_o, cmd_data_o},
              {15'd0, 1'b1, prev_reg, prev_dat});
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          cmd_done_i = 1'b1;
          cmd_nack_i = pend_nack;
        end
      end
      if (cmd_valid_o && cmd_ready_i) begin
        if (xfer_n < 64) begin
          xreg[xfer_n] = cmd_reg_o;
          xdat[xfer_n] = cmd_data_o;
          gap[xfer_n]  = run;
        end
        pend_nack = (xfer_n >= nack_at) && (xfer_n < nack_at + nack_cnt);
        xfer_n++;
        run = 0;
        cnt = 4;
      end else if (!cmd_valid_o) begin
        run++;
      end
      prev_hold = cmd_valid_o && !cmd_ready_i;
      prev_reg  = cmd_reg_o;
      prev_dat  = cmd_data_o;
    end
  end

  typedef struct {
    logic [15:0] e0, e1, e2, e3, fill;
    int          nack_at, nack_cnt;
    int          exp_xfers;
    logic        exp_done, exp_err;
    int          exp_gap1;
    logic [7:0]  r0, d0, r1, d1;
  } vec_t;

  vec_t vecs [5];

  task automatic load(input vec_t v);
    for (int i = 0; i < DEPTH; i++) rom[i] = v.fill;
    rom[0] = v.e0; rom[1] = v.e1; rom[2] = v.e2; rom[3] = v.e3;
    nack_at  = v.nack_at;
    nack_cnt = v.nack_cnt;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_i = 1'b1;
    xfer_n  = 0;
    run     = 0;
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int k;
    k = 0;
    while (!(done_o || error_o) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 2000) begin
      checks++;
      errors++;
      $display("FAIL %s timeout actual=%0d cycles required=<2000", name, k);
    end
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (!cmd_valid_o && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      checks++;
      errors++;
      $display("FAIL %s timeout actual=%0d cycles required=<200", name, k);
    end
  endtask

  initial begin
    int k;
    vecs[0] = '{16'h1280, 16'h1101, 16'hFFFF, 16'hFFFF, 16'hFFFF, -1, 0,
                2, 1'b1, 1'b0, 6, 8'h12, 8'h80, 8'h11, 8'h01};
    vecs[1] = '{16'h1280, 16'hFFF0, 16'h1101, 16'hFFFF, 16'hFFFF, -1, 0,
                2, 1'b1, 1'b0, 12, 8'h12, 8'h80, 8'h11, 8'h01};
    vecs[2] = '{16'h1280, 16'h1101, 16'h1234, 16'hFFFF, 16'hFFFF, 1, 4,
                2, 1'b0, 1'b1, 6, 8'h12, 8'h80, 8'h11, 8'h01};
    vecs[3] = '{16'h1280, 16'h1101, 16'h1234, 16'hFFFF, 16'hFFFF, 1, 1,
                2, 1'b0, 1'b1, 6, 8'h12, 8'h80, 8'h11, 8'h01};
    vecs[4] = '{16'h2001, 16'h2002, 16'h2003, 16'h2004, 16'h2100, -1, 0,
                16, 1'b1, 1'b0, 6, 8'h20, 8'h01, 8'h20, 8'h02};
`ifdef CMOS_CFG_RETRY_EN
    vecs[2].exp_xfers = 5;
    vecs[3].exp_xfers = 4;
    vecs[3].exp_done  = 1'b1;
    vecs[3].exp_err   = 1'b0;
`endif

    reset_i  = 1'b1;
    start_i  = 1'b0;
    ready_en = 1'b1;
    load(vecs[0]);
    repeat (3) @(negedge clk);

    check("rst_reset_cmos", reset_cmos_o, 0);
    check("rst_valid", cmd_valid_o, 0);
    check("rst_busy", busy_o, 1);
    check("rst_done", done_o, 0);
    check("rst_error", error_o, 0);
    check("rst_addr", rom_addr_o, 0);
    check("rst_reg_data", {cmd_reg_o, cmd_data_o}, 0);

    // Power-up timing: 2 cycles of sensor reset, 3 of wake, then fetch
    // and decode before the first command goes valid.
    xfer_n  = 0;
    reset_i = 1'b0;
    k = 0;
    while (!reset_cmos_o && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("reset_len", k, 2);
    while (!cmd_valid_o && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("first_cmd_cycle", k, 7);
    check("busy_running", busy_o, 1);
    wait_end("powerup");
    check("powerup_xfers", xfer_n, 2);
    check("powerup_done", done_o, 1);

    // start_i in DONE: sensor re-reset and replay from index 0.
    @(negedge clk);
    start_i = 1'b1;
    xfer_n  = 0;
    @(negedge clk);
    start_i = 1'b0;
    check("restart_reset_cmos", reset_cmos_o, 0);
    check("restart_busy", busy_o, 1);
    check("restart_done_clr", done_o, 0);
    wait_end("restart");
    check("restart_xfers", xfer_n, 2);
    check("restart_first_reg", {xreg[0], xdat[0]}, 16'h1280);
    check("restart_done", done_o, 1);

    for (int i = 0; i < 5; i++) begin
      load(vecs[i]);
      do_reset();
      wait_end($sformatf("vec%0d", i));
      repeat (12) @(negedge clk);
      check($sformatf("vec%0d_xfers", i), xfer_n, vecs[i].exp_xfers);
      check($sformatf("vec%0d_done", i), done_o, vecs[i].exp_done);
      check($sformatf("vec%0d_error", i), error_o, vecs[i].exp_err);
      check($sformatf("vec%0d_busy", i), busy_o, 0);
      check($sformatf("vec%0d_reset_cmos", i), reset_cmos_o, 1);
      check($sformatf("vec%0d_cmd0", i), {xreg[0], xdat[0]}, {vecs[i].r0, vecs[i].d0});
      check($sformatf("vec%0d_cmd1", i), {xreg[1], xdat[1]}, {vecs[i].r1, vecs[i].d1});
      check($sformatf("vec%0d_gap1", i), gap[1], vecs[i].exp_gap1);
    end

    // Backpressure: valid and reg/data must hold while ready is low.
    load(vecs[0]);
    ready_en = 1'b0;
    do_reset();
    wait_valid("bp_valid");
    repeat (5) @(negedge clk);
    check("bp_valid_held", cmd_valid_o, 1);
    check("bp_no_xfer", xfer_n, 0);
    check("bp_reg_data", {cmd_reg_o, cmd_data_o}, 16'h1280);
    ready_en = 1'b1;
    wait_end("bp");
    repeat (12) @(negedge clk);
    check("bp_xfers", xfer_n, 2);
    check("bp_done", done_o, 1);

    // start_i during WAIT_DONE is ignored.
    load(vecs[0]);
    do_reset();
    k = 0;
    while (xfer_n < 1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("wd_reached", k < 200, 1);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check("wd_reset_cmos", reset_cmos_o, 1);
    check("wd_busy", busy_o, 1);
    wait_end("wd");
    repeat (12) @(negedge clk);
    check("wd_xfers", xfer_n, 2);
    check("wd_done", done_o, 1);

    // reset_i while a command is pending in ISSUE.
    ready_en = 1'b0;
    do_reset();
    wait_valid("mid_valid");
    reset_i = 1'b1;
    @(negedge clk);
    check("mid_valid_drop", cmd_valid_o, 0);
    check("mid_reset_cmos", reset_cmos_o, 0);
    check("mid_busy", busy_o, 1);
    check("mid_addr", rom_addr_o, 0);
    reset_i  = 1'b0;
    ready_en = 1'b1;
    wait_end("mid");
    repeat (12) @(negedge clk);
    check("mid_xfers", xfer_n, 2);
    check("mid_done", done_o, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
